alto_t_reg_bank: RTL
====================

// Module: alto_t_reg_bank
// PURPOSE
//  Per-task T register file: NTASKS independent T registers, one per microcode task.
//  The source mux is the same as for the single T register: ALU result for ALU-source ALUF codes, bus data otherwise.
//  Writes pass through a one-entry commit stage; a bypass keeps them visible the next cycle.
//  Sits beside the ALU; dat_o feeds ALU operand B for the currently running task.
// PARAMETERS
//  WIDTH    16  datapath width in bits
//  NTASKS   16  number of per-task T registers
//  TASK_W    4  task index width; must satisfy 2**TASK_W >= NTASKS
// PORTS
//  clk_i        in   1       system clock; all state changes on posedge
//  rst_i        in   1       reset, synchronous, active-high
//  task_i       in   TASK_W  current task; selects read entry and write target
//  load_i       in   1       load T of task_i this cycle
//  bus_dat_i    in   WIDTH   processor bus data
//  alu_dat_i    in   WIDTH   ALU result
//  aluf_i       in   4       current ALU function code
//  dat_o        out  WIDTH   T value of task_i, combinational read
//  dbg_req_i    in   1       debug read request (ALTO_T_REG_DBG_EN only)
//  dbg_task_i   in   TASK_W  debug read task index (ALTO_T_REG_DBG_EN only)
//  dbg_ack_o    out  1       debug data valid, one-cycle pulse (ALTO_T_REG_DBG_EN only)
//  dbg_dat_o    out  WIDTH   debug read data (ALTO_T_REG_DBG_EN only)
// BEHAVIOUR
//  Source select: aluf_i in {BUS, BUS_OR_T, BUS_PLUS_1, BUS_MINUS_1, BUS_PLUS_T_PLUS_1, BUS_PLUS_SKIP, BUS_AND_T_ALT} -> alu_dat_i; all other codes -> bus_dat_i.
//  Stage P (pending): pend_v, pend_task, pend_dat.
//  Edge with load_i=1: P <= {1, task_i, selected data}; if pend_v was 1, the old P commits to mem[pend_task] on the same edge.
//  Edge with load_i=0: if pend_v=1, mem[pend_task] <= pend_dat and pend_v <= 0.
//  Read: dat_o = (pend_v && pend_task==task_i) ? pend_dat : mem[task_i].
//   So a load at edge N is visible on dat_o during cycle N+1, with the same latency as a plain register.
//  Back-to-back loads to the same task: the last value wins; no write is dropped or reordered.
//  Task switch with a write pending: the other task's read sees mem; the pending entry still commits.
//  task_i >= NTASKS: the load is ignored (pend_v is not set); dat_o = 0.
//  Reset: all mem entries = 0, pend_v = 0, dat_o = 0 for any task.
//   Reset mid-operation discards any pending write; reset dominates load_i in the same cycle.
//  No arithmetic in the block; data passes through unmodified at WIDTH bits.
// CONFIGURATION
//  Macro ALTO_T_REG_DBG_EN, defined: debug read port present.
//   A request is accepted when dbg_req_i=1 and dbg_ack_o=0.
//   At acceptance, dbg_dat_o captures the bypassed value of dbg_task_i, using the same bypass rule as dat_o.
//   dbg_ack_o=1 for exactly the next cycle. A held request is therefore served every second cycle.
//   Reset: dbg_ack_o=0, dbg_dat_o=0.
//  Macro ALTO_T_REG_DBG_EN, undefined: dbg_* ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  The ALTO_ALUF_* codes stay in alto_definitions.v.
//  Add a shared function alto_aluf_t_from_alu(aluf) returning 1 for the ALU-source set.
//   The single T register uses the same function, so the set is defined in one place.
//  Sub-module alto_t_src_sel: combinational source mux (aluf, bus, alu -> data).
//  The rest (mem array, P stage, bypass, debug port) is flat in this module.
// TESTING
//  1 Reset then sweep task_i 0..15 -> dat_o=0 for every task.
//  2 task 3, aluf=BUS, load, alu=16'h1234, bus=16'hFFFF -> dat_o=16'h1234 next cycle.
//    Then a non-ALU code with bus=16'h00AA, load -> dat_o=16'h00AA next cycle.
//  3 task 5: loads of 16'h0001, 16'h0002 on consecutive cycles, then idle
//    -> dat_o=0001, then 0002, then 0002 stable; mem[5]=0002.
//  4 Load task 2 = 16'hBEEF, switch to task 7 next cycle -> dat_o=0 for task 7;
//    back to task 2 two cycles later -> 16'hBEEF.
//  5 Load task 1 = 16'h5555 with rst_i=1 in the following cycle -> task 1 reads 0 after reset; no late commit appears.
//  6 (DBG_EN) Load task 4 = 16'hCAFE; next cycle dbg_req_i=1, dbg_task_i=4 -> dbg_ack_o=1 one cycle later with dbg_dat_o=16'hCAFE.
//    A held request -> ack on alternate cycles.

Source files
------------

// File: rtl/alto_t_reg_bank_pkg.sv
// ============================================================================
// Module : alto_t_reg_bank_pkg
// Brief  : ALU function codes and the shared T-source classification function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alto_t_reg_bank_pkg;

    localparam logic [3:0] ALTO_ALUF_BUS               = 4'd0;
    localparam logic [3:0] ALTO_ALUF_T                 = 4'd1;
    localparam logic [3:0] ALTO_ALUF_BUS_OR_T          = 4'd2;
    localparam logic [3:0] ALTO_ALUF_BUS_AND_T         = 4'd3;
    localparam logic [3:0] ALTO_ALUF_BUS_XOR_T         = 4'd4;
    localparam logic [3:0] ALTO_ALUF_BUS_PLUS_1        = 4'd5;
    localparam logic [3:0] ALTO_ALUF_BUS_MINUS_1       = 4'd6;
    localparam logic [3:0] ALTO_ALUF_BUS_PLUS_T        = 4'd7;
    localparam logic [3:0] ALTO_ALUF_BUS_MINUS_T       = 4'd8;
    localparam logic [3:0] ALTO_ALUF_BUS_MINUS_T_MINUS_1 = 4'd9;
    localparam logic [3:0] ALTO_ALUF_BUS_PLUS_T_PLUS_1 = 4'd10;
    localparam logic [3:0] ALTO_ALUF_BUS_PLUS_SKIP     = 4'd11;
    localparam logic [3:0] ALTO_ALUF_BUS_AND_T_ALT     = 4'd12;
    localparam logic [3:0] ALTO_ALUF_BUS_AND_NOT_T     = 4'd13;

    // Single definition of which ALU functions load T from the ALU output;
    // shared with the single-T register so the set cannot drift.
    function automatic logic alto_aluf_t_from_alu(input logic [3:0] aluf);
        case (aluf)
            ALTO_ALUF_BUS,
            ALTO_ALUF_BUS_OR_T,
            ALTO_ALUF_BUS_PLUS_1,
            ALTO_ALUF_BUS_MINUS_1,
            ALTO_ALUF_BUS_PLUS_T_PLUS_1,
            ALTO_ALUF_BUS_PLUS_SKIP,
            ALTO_ALUF_BUS_AND_T_ALT:   return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/alto_t_reg_bank_src_sel.sv
// ============================================================================
// Module : alto_t_src_sel
// Brief  : Combinational T source mux: ALU result or bus data by ALU function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alto_t_src_sel
    import alto_t_reg_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       aluf,
    input  logic [WIDTH-1:0] bus_dat,
    input  logic [WIDTH-1:0] alu_dat,
    output logic [WIDTH-1:0] dat
);

    assign dat = alto_aluf_t_from_alu(aluf) ? alu_dat : bus_dat;

endmodule

`default_nettype wire

// File: rtl/alto_t_reg_bank.sv
// ============================================================================
// Module : alto_t_reg_bank
// Brief  : Per-task T register file with one-entry commit stage and read bypass.
//          Optional debug read port enabled by macro ALTO_T_REG_DBG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alto_t_reg_bank
    import alto_t_reg_bank_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NTASKS = 16,
    parameter int TASK_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [TASK_W-1:0] task_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  bus_dat_i,
    input  logic [WIDTH-1:0]  alu_dat_i,
    input  logic [3:0]        aluf_i,
`ifdef ALTO_T_REG_DBG_EN
    input  logic              dbg_req_i,
    input  logic [TASK_W-1:0] dbg_task_i,
    output logic              dbg_ack_o,
    output logic [WIDTH-1:0]  dbg_dat_o,
`endif
    output logic [WIDTH-1:0]  dat_o
);

    logic [WIDTH-1:0]  r_mem [NTASKS];
    logic              r_pend_v;
    logic [TASK_W-1:0] r_pend_task;
    logic [WIDTH-1:0]  r_pend_dat;

    logic [WIDTH-1:0]  w_src_dat;
    logic              w_task_ok;

    alto_t_src_sel #(
        .WIDTH   (WIDTH)
    ) u_src_sel (
        .aluf    (aluf_i),
        .bus_dat (bus_dat_i),
        .alu_dat (alu_dat_i),
        .dat     (w_src_dat)
    );

    assign w_task_ok = (int'(task_i) < NTASKS);

    // The pending entry always drains, whether or not a new load replaces it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NTASKS; i++) begin
                r_mem[i] <= '0;
            end
            r_pend_v    <= 1'b0;
            r_pend_task <= '0;
            r_pend_dat  <= '0;
        end else begin
            if (r_pend_v) begin
                r_mem[r_pend_task] <= r_pend_dat;
            end
            if (load_i && w_task_ok) begin
                r_pend_v    <= 1'b1;
                r_pend_task <= task_i;
                r_pend_dat  <= w_src_dat;
            end else begin
                r_pend_v    <= 1'b0;
            end
        end
    end

    always_comb begin
        dat_o = '0;
        if (w_task_ok) begin
            if (r_pend_v && (r_pend_task == task_i)) begin
                dat_o = r_pend_dat;
            end else begin
                dat_o = r_mem[task_i];
            end
        end
    end

`ifdef ALTO_T_REG_DBG_EN
    logic             w_dbg_task_ok;
    logic [WIDTH-1:0] w_dbg_rd;

    assign w_dbg_task_ok = (int'(dbg_task_i) < NTASKS);

    always_comb begin
        w_dbg_rd = '0;
        if (w_dbg_task_ok) begin
            if (r_pend_v && (r_pend_task == dbg_task_i)) begin
                w_dbg_rd = r_pend_dat;
            end else begin
                w_dbg_rd = r_mem[dbg_task_i];
            end
        end
    end

    // Ack blocks acceptance, so a held request is served every other cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dbg_ack_o <= 1'b0;
            dbg_dat_o <= '0;
        end else if (dbg_req_i && !dbg_ack_o) begin
            dbg_ack_o <= 1'b1;
            dbg_dat_o <= w_dbg_rd;
        end else begin
            dbg_ack_o <= 1'b0;
        end
    end
`endif

endmodule

`default_nettype wire
